// File: rtl/s3_execute_stage_pkg.sv
// Shared widths and ALU opcodes for the lab pipeline (decode, stage-2, execute).
package s3_execute_stage_pkg;

  localparam int DATA_W = 32;
  localparam int IMM_W  = 16;
  localparam int REG_W  = 5;
  localparam int OP_W   = 3;

  typedef enum logic [OP_W-1:0] {
    ALU_PASS = 3'b000,
    ALU_NOT  = 3'b001,
    ALU_ADD  = 3'b010,
    ALU_SUB  = 3'b011,
    ALU_OR   = 3'b100,
    ALU_AND  = 3'b101,
    ALU_XOR  = 3'b110,
    ALU_SLT  = 3'b111
  } alu_op_e;

  function automatic logic [DATA_W-1:0] sign_ext_imm(input logic [IMM_W-1:0] imm);
    return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

endpackage

// File: rtl/s3_execute_stage_alu.sv
// Combinational ALU of the execute stage; add/sub wrap modulo 2^32, SLT is signed.
module s3_execute_stage_alu
  import s3_execute_stage_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [OP_W-1:0]   op,
  output logic [DATA_W-1:0] result
);

  always_comb begin
    result = '0;
    case (alu_op_e'(op))
      ALU_PASS: result = a;
      ALU_NOT:  result = ~a;
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_OR:   result = a | b;
      ALU_AND:  result = a & b;
      ALU_XOR:  result = a ^ b;
      ALU_SLT:  result = ($signed(a) < $signed(b)) ? DATA_W'(1) : '0;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/s3_execute_stage.sv
// Execute stage: operand muxes, ALU, EX/MEM register with stall/flush, write counter.
// Optional operand forwarding from the EX/MEM register when S3_FORWARD_EN is defined.
module s3_execute_stage
  import s3_execute_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] S2_ReadData1,
  input  logic [DATA_W-1:0] S2_ReadData2,
  input  logic [IMM_W-1:0]  S2_Imm,
  input  logic              S2_DataSrc,
  input  logic [OP_W-1:0]   S2_ALUOp,
  input  logic [REG_W-1:0]  S2_WriteSelect,
  input  logic              S2_WriteEnable,
  input  logic [REG_W-1:0]  S2_ReadSelect1,
  input  logic [REG_W-1:0]  S2_ReadSelect2,
  input  logic              stall,
  input  logic              flush,
  output logic [DATA_W-1:0] S3_ALUOut,
  output logic [REG_W-1:0]  S3_WriteSelect,
  output logic              S3_WriteEnable,
  output logic              S3_Zero,
  output logic [DATA_W-1:0] S3_WriteCount
);

  // No handshake: stall and flush are level controls sampled every rising edge,
  // with priority rst > flush > stall > load.
  logic [DATA_W-1:0] reg_a;
  logic [DATA_W-1:0] reg_b;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] write_count;

`ifdef S3_FORWARD_EN
  logic fwd_a;
  logic fwd_b;
  // The held EX/MEM value stays the forward source while stalled.
  assign fwd_a = S3_WriteEnable && (S3_WriteSelect != '0) && (S2_ReadSelect1 == S3_WriteSelect);
  assign fwd_b = S3_WriteEnable && (S3_WriteSelect != '0) && (S2_ReadSelect2 == S3_WriteSelect);
  assign reg_a = fwd_a ? S3_ALUOut : S2_ReadData1;
  assign reg_b = fwd_b ? S3_ALUOut : S2_ReadData2;
`else
  logic [2*REG_W-1:0] unused_sel;
  assign unused_sel = {S2_ReadSelect1, S2_ReadSelect2};
  assign reg_a = S2_ReadData1;
  assign reg_b = S2_ReadData2;
`endif

  assign op_a = reg_a;
  assign op_b = S2_DataSrc ? sign_ext_imm(S2_Imm) : reg_b;

  s3_execute_stage_alu u_alu (
    .a      (op_a),
    .b      (op_b),
    .op     (S2_ALUOp),
    .result (alu_result)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      S3_ALUOut      <= '0;
      S3_WriteSelect <= '0;
      S3_WriteEnable <= 1'b0;
      S3_Zero        <= 1'b0;
      write_count    <= '0;
    end else if (flush) begin
      S3_ALUOut      <= '0;
      S3_WriteSelect <= '0;
      S3_WriteEnable <= 1'b0;
      S3_Zero        <= 1'b0;
    end else if (!stall) begin
      S3_ALUOut      <= alu_result;
      S3_WriteSelect <= S2_WriteSelect;
      S3_WriteEnable <= S2_WriteEnable;
      S3_Zero        <= (alu_result == '0);
      if (S2_WriteEnable) write_count <= write_count + DATA_W'(1);
    end
  end

  assign S3_WriteCount = write_count;

endmodule

// File: tb/tb_s3_execute_stage.sv
// Self-checking bench for s3_execute_stage: directed cases then randomized traffic
// against a behavioural model. Build with +define+S3_FORWARD_EN to cover forwarding.
module tb_s3_execute_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] rd1, rd2;
  logic [15:0] imm;
  logic        ds;
  logic [2:0]  op;
  logic [4:0]  ws;
  logic        we;
  logic [4:0]  rs1, rs2;
  logic        stall, flush;
  logic [31:0] alu_out;
  logic [4:0]  out_sel;
  logic        out_we;
  logic        out_zero;
  logic [31:0] out_cnt;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] m_out;
  logic [4:0]  m_sel;
  logic        m_we;
  logic        m_zero;
  logic [31:0] m_cnt;

  s3_execute_stage dut (
    .clk            (clk),
    .rst            (rst),
    .S2_ReadData1   (rd1),
    .S2_ReadData2   (rd2),
    .S2_Imm         (imm),
    .S2_DataSrc     (ds),
    .S2_ALUOp       (op),
    .S2_WriteSelect (ws),
    .S2_WriteEnable (we),
    .S2_ReadSelect1 (rs1),
    .S2_ReadSelect2 (rs2),
    .stall          (stall),
    .flush          (flush),
    .S3_ALUOut      (alu_out),
    .S3_WriteSelect (out_sel),
    .S3_WriteEnable (out_we),
    .S3_Zero        (out_zero),
    .S3_WriteCount  (out_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [2:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
    int signed sa, sb;
    sa = a;
    sb = b;
    case (o)
      3'd0: return a;
      3'd1: return ~a;
      3'd2: return 32'(a + b);
      3'd3: return 32'(a - b);
      3'd4: return a | b;
      3'd5: return a & b;
      3'd6: return a ^ b;
      default: return (sa < sb) ? 32'd1 : 32'd0;
    endcase
  endfunction

  // Reference for one clock edge, from the architectural rules.
  task automatic model_edge();
    logic [31:0] a, b, r;
    if (rst) begin
      m_out = 0; m_sel = 0; m_we = 0; m_zero = 0; m_cnt = 0;
    end else if (flush) begin
      m_out = 0; m_sel = 0; m_we = 0; m_zero = 0;
    end else if (!stall) begin
      a = rd1;
      b = rd2;
`ifdef S3_FORWARD_EN
      if (m_we && m_sel != 0 && rs1 == m_sel) a = m_out;
      if (m_we && m_sel != 0 && rs2 == m_sel) b = m_out;
`endif
      if (ds) b = {{16{imm[15]}}, imm};
      r = ref_alu(op, a, b);
      m_out = r;
      m_sel = ws;
      m_we = we;
      m_zero = (r == 0);
      if (we) m_cnt = m_cnt + 1;
    end
  endtask

  // driver tasks
  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [15:0] i,
                       input logic d, input logic [2:0] o, input logic [4:0] s,
                       input logic w, input logic [4:0] r1, input logic [4:0] r2,
                       input logic st, input logic fl);
    rd1 = a; rd2 = b; imm = i; ds = d; op = o; ws = s; we = w;
    rs1 = r1; rs2 = r2; stall = st; flush = fl;
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check({tag, ".out"},  alu_out, m_out);
    check({tag, ".sel"},  {27'd0, out_sel}, {27'd0, m_sel});
    check({tag, ".we"},   {31'd0, out_we}, {31'd0, m_we});
    check({tag, ".zero"}, {31'd0, out_zero}, {31'd0, m_zero});
    check({tag, ".cnt"},  out_cnt, m_cnt);
  endtask

  initial begin
    m_out = 0; m_sel = 0; m_we = 0; m_zero = 0; m_cnt = 0;
    rst = 1'b1;
    drive(32'hDEAD_BEEF, 32'h1234, 16'h0, 1'b0, 3'd2, 5'd9, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0);
    @(negedge clk);
    tick("reset");
    check("reset_out", alu_out, 32'd0);
    check("reset_cnt", out_cnt, 32'd0);
    rst = 1'b0;

    drive(32'd5, 32'd7, 16'h0, 1'b0, 3'b010, 5'd3, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0);
    tick("add");
    check("add_out", alu_out, 32'd12);
    check("add_sel", {27'd0, out_sel}, 32'd3);
    check("add_cnt", out_cnt, 32'd1);

    drive(32'd1, 32'd0, 16'hFFFE, 1'b1, 3'b010, 5'd5, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
    tick("imm");
    check("imm_out", alu_out, 32'hFFFF_FFFF);

    drive(32'hFFFF_FFFF, 32'd1, 16'h0, 1'b0, 3'b111, 5'd6, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0);
    tick("slt");
    check("slt_out", alu_out, 32'd1);

    drive(32'd9, 32'd9, 16'h0, 1'b0, 3'b011, 5'd7, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0);
    tick("sub");
    check("sub_zero", {31'd0, out_zero}, 32'd1);

    drive(32'hFFFF_FFFF, 32'd1, 16'h0, 1'b0, 3'b010, 5'd8, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
    tick("wrap");
    check("wrap_out", alu_out, 32'd0);

    drive(32'd40, 32'd2, 16'h0, 1'b0, 3'b110, 5'd2, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0);
    tick("pre_stall");
    for (int k = 0; k < 3; k++) begin
      drive($urandom, $urandom, 16'($urandom), 1'($urandom), 3'($urandom), 5'($urandom),
            1'b1, 5'd0, 5'd0, 1'b1, 1'b0);
      tick("stall");
      check("stall_out", alu_out, 32'd42);
    end
    drive(32'd3, 32'd3, 16'h0, 1'b0, 3'b010, 5'd4, 1'b1, 5'd0, 5'd0, 1'b1, 1'b1);
    tick("flush_stall");
    check("flush_we", {31'd0, out_we}, 32'd0);
    check("flush_cnt", out_cnt, 32'd4);

    // counter wrap via preset
    force dut.write_count = 32'hFFFF_FFFF;
    #1;
    release dut.write_count;
    m_cnt = 32'hFFFF_FFFF;
    check("cnt_preset", out_cnt, 32'hFFFF_FFFF);
    drive(32'd1, 32'd1, 16'h0, 1'b0, 3'b010, 5'd1, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0);
    tick("cnt_wrap");
    check("cnt_wrap0", out_cnt, 32'd0);

`ifdef S3_FORWARD_EN
    drive(32'd20, 32'd0, 16'h0, 1'b0, 3'b000, 5'd4, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0);
    tick("fwd_src");
    drive(32'd0, 32'd1, 16'h0, 1'b0, 3'b010, 5'd9, 1'b1, 5'd4, 5'd0, 1'b0, 1'b0);
    tick("fwd_a");
    check("fwd_a_out", alu_out, 32'd21);
    drive(32'd20, 32'd0, 16'h0, 1'b0, 3'b000, 5'd0, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0);
    tick("fwd_r0_src");
    drive(32'd0, 32'd1, 16'h0, 1'b0, 3'b010, 5'd9, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0);
    tick("fwd_r0");
    check("fwd_r0_out", alu_out, 32'd1);
`endif

    // randomized traffic; small register range makes forwarding hits frequent
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a, b;
      a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 4)) : $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      drive(a, b, 16'($urandom), 1'($urandom), 3'($urandom_range(0, 7)),
            5'($urandom_range(0, 5)), 1'($urandom), 5'($urandom_range(0, 5)),
            5'($urandom_range(0, 5)), ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 9) == 0));
      rst = ($urandom_range(0, 79) == 0);
      tick("rand");
      rst = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/s3_execute_stage.md
# s3_execute_stage

Execute stage of the five-stage lab pipeline, directly downstream of the stage-2 (ID/EX) register. Consumes the registered operands, immediate, ALU opcode, data-source select and write-back controls, computes the ALU result, and captures it with the write-back controls into the stage-3 (EX/MEM) register. Supports stall (hold) and flush (bubble insertion), and keeps a count of committed writes.

## Interface
- No parameters; widths fixed: data 32, immediate 16, register select 5, ALU op 3.
- clk  input  1  pipeline clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- S2_ReadData1  input  32  operand A from stage-2 register
- S2_ReadData2  input  32  operand B candidate from stage-2 register
- S2_Imm  input  16  immediate from stage-2 register
- S2_DataSrc  input  1  0: operand B = S2_ReadData2; 1: operand B = sign-extended S2_Imm
- S2_ALUOp  input  3  ALU operation
- S2_WriteSelect  input  5  destination register
- S2_WriteEnable  input  1  instruction writes back
- S2_ReadSelect1  input  5  source register of operand A (used only with forwarding)
- S2_ReadSelect2  input  5  source register of operand B (used only with forwarding)
- stall  input  1  hold stage-3 register
- flush  input  1  load a bubble into stage-3 register
- S3_ALUOut  output  32  registered ALU result
- S3_WriteSelect  output  5  registered destination
- S3_WriteEnable  output  1  registered write enable
- S3_Zero  output  1  registered flag, 1 when result equals 0
- S3_WriteCount  output  32  committed-write counter

## Operation
- ALU ops: 000 pass A; 001 NOT A; 010 A+B; 011 A−B; 100 A|B; 101 A&B; 110 A^B; 111 SLT signed (result 32'd1 or 32'd0).
- Add/sub are modulo 2^32; carry and overflow are discarded.
- Immediate: bit 15 replicated into bits 31:16.
- Update priority per edge: rst > flush > stall > load.
- rst: all outputs to 0, including S3_WriteCount.
- flush: S3_ALUOut 0, S3_WriteSelect 0, S3_WriteEnable 0, S3_Zero 0; counter unchanged.
- stall (no flush): all S3 outputs and counter hold.
- load: capture ALU result, S2_WriteSelect, S2_WriteEnable, and zero flag; counter increments by 1 iff S2_WriteEnable=1.
- Counter wraps FFFF_FFFF → 0.
- S2_WriteEnable=1 with S2_WriteSelect=0 is loaded unchanged; the register file ignores writes to register 0.

## Timing
- One-cycle latency: stage-2 inputs presented in cycle n appear on S3 outputs after edge n+1.
- ALU and operand muxes are purely combinational between the stage-2 inputs and the stage-3 register.
- No handshake; stall and flush are sampled every edge; simultaneous flush+stall gives a bubble.
- Reset asserted mid-stream clears the register on that edge; the first load follows the first edge with rst low.

## Configuration
- S3_FORWARD_EN defined: operand A = S3_ALUOut when S3_WriteEnable=1, S3_WriteSelect≠0, and S2_ReadSelect1 == S3_WriteSelect; otherwise S2_ReadData1. Operand B (register path, DataSrc=0 only) is forwarded by the same rule using S2_ReadSelect2. During stall the held S3 value remains the forward source.
- Undefined: S2_ReadSelect1/2 are ignored and operands come only from the stage-2 inputs; hazards are resolved upstream by stalls.

## Structure
- Shared package: ALU opcode constants (ALU_PASS…ALU_SLT) and the width constants for data, immediate and register select, reused by decode and stage-2.
- Sub-module alu: combinational; inputs a, b (32-bit) and op (3-bit); output result. The stage module holds the operand muxes, forwarding logic, stage-3 register and counter.

## Test plan
- Reset then load ALUOp=010, A=5, ReadData2=7, DataSrc=0, WE=1, sel=3 → next edge: ALUOut=12, WriteSelect=3, WE=1, Zero=0, WriteCount=1.
- DataSrc=1, Imm=16'hFFFE, A=1, op=010 → ALUOut=FFFF_FFFF; op=111 with A=FFFF_FFFF, B=1 → ALUOut=1.
- op=011, A=B=9 → ALUOut=0, Zero=1; op=010, A=FFFF_FFFF, B=1 → ALUOut=0 (wrap).
- Stall for 3 cycles while inputs change → outputs and counter frozen; flush+stall together → WE=0, ALUOut=0, counter unchanged.
- Counter preset to FFFF_FFFF via loads (or forced), then one WE=1 load → WriteCount=0.
- With S3_FORWARD_EN: S3 holds sel=4, ALUOut=20, WE=1; next instruction ReadSelect1=4, ReadData1=0, op=010, B=1 → ALUOut=21. With sel=0 in S3 → no forward (ALUOut=1).
